// File: rtl/seq_addr_counter_pkg.sv
// Shared state encodings and sizing helpers for the ROM address sequencer.
// The encodings match those used by the round FSM.
package seq_addr_counter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int presc_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/seq_addr_counter_prescaler.sv
// Clock-enable divider: one tick every DIV enabled clocks.
// clr restarts the count and suppresses the tick in the same cycle.
module tick_prescaler
   import seq_addr_counter_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic R,
   input  logic E,
   input  logic clr,
   output logic tick
);

   localparam int PW = presc_w(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] cnt;

   assign tick = E && !clr && (cnt == LAST);

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (E) begin
         cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/seq_addr_counter.sv
// ROM address sequencer: steps 0..limit once per prescaler tick,
// one-shot (sticky tc) or looping (tc pulse per pass).
module seq_addr_counter
   import seq_addr_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 1,
   parameter int LOOP  = 0
) (
   input  logic             clk,
   input  logic             R,
   input  logic             E,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] SEQFPGA,
   output logic             tc,
   output logic             busy,
   output logic             step
);

   state_t           state;
   logic [WIDTH-1:0] limit;
   logic             tick;
   logic             en;
   logic             at_lim;

   assign en     = E && (state == S_RUN);
   assign at_lim = (SEQFPGA == limit);

   tick_prescaler #(
      .DIV (DIV)
   ) u_presc (
      .clk  (clk),
      .R    (R),
      .E    (en),
      .clr  (start || abort),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state   <= S_IDLE;
         limit   <= '0;
         SEQFPGA <= '0;
         tc      <= 1'b0;
         busy    <= 1'b0;
         step    <= 1'b0;
      end else begin
         step <= 1'b0;
         if (abort) begin
            state   <= S_IDLE;
            SEQFPGA <= '0;
            tc      <= 1'b0;
            busy    <= 1'b0;
         end else if (start) begin
            state   <= S_RUN;
            limit   <= data;
            SEQFPGA <= '0;
            tc      <= 1'b0;
            busy    <= 1'b1;
            step    <= 1'b1;
         end else begin
            unique case (state)
               S_RUN: begin
                  // tc in RUN is only ever the one-cycle wrap pulse
                  tc <= 1'b0;
                  if (tick) begin
                     if (!at_lim) begin
                        SEQFPGA <= SEQFPGA + WIDTH'(1);
                        step    <= 1'b1;
                     end else if (LOOP != 0) begin
                        SEQFPGA <= '0;
                        tc      <= 1'b1;
                        step    <= 1'b1;
                     end else begin
                        state   <= S_DONE;
                        SEQFPGA <= '0;
                        tc      <= 1'b1;
                        busy    <= 1'b0;
                     end
                  end
               end
               S_IDLE, S_DONE: begin
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
